rtc_time_date_counter: RTL and testbench
========================================

Name: rtc_time_date_counter

Overview:
Real-time clock/calendar core of the alarm clock. It divides the system clock into a 1 Hz tick and keeps the current time (hh:mm:ss) and date (yy-mm-dd, years 2000–2099). It accepts validated user set requests. It sits directly upstream of the display decoder and drives the decoder's packed time and date inputs with the same bit layout.

Parameters:
CLK_HZ, 1000, system clock cycles per second; prescaler terminal count is CLK_HZ-1.
RST_YEAR, 16, year field value after reset (0–99).

Ports:
CLK  in  1  system clock, rising edge.
RESETN  in  1  asynchronous active-low reset.
IN_RUN  in  1  1 = time advances; 0 = prescaler and counters hold.
IN_SET_TIME  in  1  one-cycle strobe: load IN_TIME_VAL.
IN_TIME_VAL  in  17  time to load: hour[16:12], min[11:6], sec[5:0].
IN_SET_DATE  in  1  one-cycle strobe: load IN_DATE_VAL.
IN_DATE_VAL  in  16  date to load: year[15:9], month[8:5], day[4:0].
OUT_TIME  out  17  current time, same layout as IN_TIME_VAL.
OUT_DATE  out  16  current date, same layout as IN_DATE_VAL.
OUT_SEC_TICK  out  1  one-cycle pulse in the cycle the seconds field advances.
OUT_SET_ERR  out  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset (async assert, sync release): OUT_TIME = 00:00:00; OUT_DATE = RST_YEAR-01-01; prescaler = 0; OUT_SEC_TICK = 0; OUT_SET_ERR = 0.
- Prescaler: counts 0..CLK_HZ-1 while IN_RUN = 1 and holds while IN_RUN = 0.
  - An internal tick occurs on the cycle the count equals CLK_HZ-1; the count then wraps to 0.
- Tick effect, applied at the clock edge ending the tick cycle:
  - sec+1.
  - sec 59 -> 0 with min+1.
  - min 59 -> 0 with hour+1.
  - hour 23 -> 0 with day+1.
- Day rollover: day equal to days_in_month(month, year) -> 1 with month+1.
- Month rollover: month 12 -> 1 with year+1.
- Year rollover: 99 -> 0.
- Month lengths: 31/28/31/30/31/30/31/31/30/31/30/31. February is 29 when year[1:0] == 0 (year 0 is leap).
- OUT_SEC_TICK is registered and is high the cycle after the tick edge, i.e. coincident with the new OUT_TIME value.
- Time set validation: hour ≤ 23, min ≤ 59, sec ≤ 59.
  - Valid: OUT_TIME loads next edge and the prescaler clears to 0, so a full second elapses before the next tick.
  - Invalid: no state change; OUT_SET_ERR pulses the next cycle.
- Date set validation: year ≤ 99, 1 ≤ month ≤ 12, 1 ≤ day ≤ days_in_month(month, year). The check uses the requested month and year.
  - Valid: OUT_DATE loads next edge; the prescaler is unaffected.
  - Invalid: ignored, with an OUT_SET_ERR pulse.
- Simultaneous events:
  - Set beats tick for its own field group. Valid IN_SET_TIME in a tick cycle: the loaded value wins and the tick is discarded, so no OUT_SEC_TICK.
  - Valid IN_SET_DATE in a cycle whose tick rolls past midnight: the date equals IN_DATE_VAL and the time still rolls to 00:00:00.
  - Both strobes together: each is validated and applied independently. OUT_SET_ERR pulses if either is rejected.
- Set strobes are honoured regardless of IN_RUN.
- Out-of-range state cannot arise, because all loads are validated.
- Latency: set-to-output is 1 cycle; tick-to-output is 1 cycle.
- Reset asserted mid-second returns everything to reset values immediately. The first tick after release occurs CLK_HZ cycles after release, with IN_RUN = 1.

Decomposition:
- Shared package holds:
  - Field bit positions and widths for the time and date words. The display decoder uses the same positions.
  - A days_in_month(month, year) function.
  - Constants: MAX_HOUR = 23, MAX_MIN = 59, MAX_SEC = 59, MAX_YEAR = 99.
- Sub-module rtc_prescaler (parameter CLK_HZ): ports CLK, RESETN, IN_RUN, IN_CLR; output TICK.
- The calendar and validation logic stays in the top module.

Test Plan:
- Reset, IN_RUN = 1, CLK_HZ = 4, RST_YEAR = 16 -> OUT_TIME 00:00:00, OUT_DATE 16-01-01; OUT_SEC_TICK first high 4 cycles after release, OUT_TIME 00:00:01.
- Set time 23:59:59 and date 16-02-28; wait 1 tick -> 00:00:00, 16-02-29. Set 16-02-29 at 23:59:59; 1 tick -> 16-03-01. Repeat with year 17 and 02-28 -> 17-03-01.
- Set time 23:59:59 and date 99-12-31; 1 tick -> 00:00:00, 00-01-01.
- Invalid sets, hour 24 / min 60 / date 17-02-29 / month 13 / day 0 -> OUT_SET_ERR pulses once each; outputs unchanged.
- IN_SET_TIME 12:34:56 on the tick cycle -> OUT_TIME 12:34:56, no OUT_SEC_TICK; next tick exactly CLK_HZ cycles later -> 12:34:57.
- IN_RUN = 0 for 10 seconds -> no ticks and time frozen. Assert RESETN low mid-count -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/rtc_time_date_counter_pkg.sv
// Shared field layout, limits and month-length helper for the RTC
// time/date words; the display decoder uses the same positions.
package rtc_time_date_counter_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 6;
    localparam int HOUR_LSB = 12;
    localparam int DAY_LSB  = 0;
    localparam int MON_LSB  = 5;
    localparam int YEAR_LSB = 9;

    localparam int TIME_W = 17;
    localparam int DATE_W = 16;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
    localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;
    localparam logic [MON_W-1:0]  MAX_MON  = 4'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [MON_W-1:0]  month;
        logic [DAY_W-1:0]  day;
    } rtc_date_t;

    // Every year divisible by 4 is leap; 2000 counts, 2100 is out of range.
    function automatic logic [DAY_W-1:0] days_in_month(
        input logic [MON_W-1:0]  month,
        input logic [YEAR_W-1:0] year
    );
        logic [DAY_W-1:0] d;
        case (month)
            4'd2:    d = ((year & 7'd3) == 7'd0) ? 5'd29 : 5'd28;
            4'd4,
            4'd6,
            4'd9,
            4'd11:   d = 5'd30;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rtc_time_date_counter_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles
// of IN_RUN; IN_CLR restarts the second.
module rtc_prescaler #(
    parameter int CLK_HZ = 1000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic IN_RUN,
    input  logic IN_CLR,
    output logic TICK
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign TICK = IN_RUN && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (IN_CLR) begin
            cnt_d = '0;
        end else if (TICK) begin
            cnt_d = '0;
        end else if (IN_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_time_date_counter.sv
// Real-time clock/calendar: 1 Hz time keeping with validated time and
// date loads; years 2000-2099 stored as 0-99.
module rtc_time_date_counter
    import rtc_time_date_counter_pkg::*;
#(
    parameter int CLK_HZ   = 1000,
    parameter int RST_YEAR = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              IN_RUN,
    input  logic              IN_SET_TIME,
    input  logic [TIME_W-1:0] IN_TIME_VAL,
    input  logic              IN_SET_DATE,
    input  logic [DATE_W-1:0] IN_DATE_VAL,
    output logic [TIME_W-1:0] OUT_TIME,
    output logic [DATE_W-1:0] OUT_DATE,
    output logic              OUT_SEC_TICK,
    output logic              OUT_SET_ERR
);

    rtc_time_t time_q, time_d, set_t;
    rtc_date_t date_q, date_d, set_d;
    logic      tick_q, tick_d;
    logic      err_q, err_d;

    logic tick, tick_eff;
    logic time_ok, date_ok;
    logic time_ld, date_ld;
    logic sec_wrap, min_wrap, hour_wrap;
    logic day_wrap, mon_wrap, year_wrap;

    assign set_t.hour  = IN_TIME_VAL[HOUR_LSB +: HOUR_W];
    assign set_t.min   = IN_TIME_VAL[MIN_LSB  +: MIN_W];
    assign set_t.sec   = IN_TIME_VAL[SEC_LSB  +: SEC_W];
    assign set_d.year  = IN_DATE_VAL[YEAR_LSB +: YEAR_W];
    assign set_d.month = IN_DATE_VAL[MON_LSB  +: MON_W];
    assign set_d.day   = IN_DATE_VAL[DAY_LSB  +: DAY_W];

    assign time_ok = (set_t.hour <= MAX_HOUR)
                  && (set_t.min  <= MAX_MIN)
                  && (set_t.sec  <= MAX_SEC);

    assign date_ok = (set_d.year  <= MAX_YEAR)
                  && (set_d.month >= 4'd1)
                  && (set_d.month <= MAX_MON)
                  && (set_d.day   >= 5'd1)
                  && (set_d.day   <= days_in_month(set_d.month, set_d.year));

    assign time_ld = IN_SET_TIME && time_ok;
    assign date_ld = IN_SET_DATE && date_ok;

    // A valid time load restarts the second and swallows a coincident tick.
    rtc_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .CLK    (CLK),
        .RESETN (RESETN),
        .IN_RUN (IN_RUN),
        .IN_CLR (time_ld),
        .TICK   (tick)
    );

    assign tick_eff  = tick && !time_ld;
    assign sec_wrap  = (time_q.sec  == MAX_SEC);
    assign min_wrap  = (time_q.min  == MAX_MIN);
    assign hour_wrap = (time_q.hour == MAX_HOUR);
    assign day_wrap  = (date_q.day == days_in_month(date_q.month, date_q.year));
    assign mon_wrap  = (date_q.month == MAX_MON);
    assign year_wrap = (date_q.year  == MAX_YEAR);

    always_comb begin
        time_d = time_q;
        date_d = date_q;
        if (tick_eff) begin
            time_d.sec = sec_wrap ? '0 : time_q.sec + 6'd1;
            if (sec_wrap) begin
                time_d.min = min_wrap ? '0 : time_q.min + 6'd1;
                if (min_wrap) begin
                    time_d.hour = hour_wrap ? '0 : time_q.hour + 5'd1;
                    if (hour_wrap) begin
                        date_d.day = day_wrap ? 5'd1 : date_q.day + 5'd1;
                        if (day_wrap) begin
                            date_d.month = mon_wrap ? 4'd1 : date_q.month + 4'd1;
                            if (mon_wrap) begin
                                date_d.year = year_wrap ? '0 : date_q.year + 7'd1;
                            end
                        end
                    end
                end
            end
        end
        if (time_ld) begin
            time_d = set_t;
        end
        if (date_ld) begin
            date_d = set_d;
        end
    end

    always_comb begin
        tick_d = tick_eff;
        err_d  = (IN_SET_TIME && !time_ok) || (IN_SET_DATE && !date_ok);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            time_q       <= '0;
            date_q.year  <= YEAR_W'(RST_YEAR);
            date_q.month <= 4'd1;
            date_q.day   <= 5'd1;
            tick_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            time_q <= time_d;
            date_q <= date_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign OUT_TIME     = time_q;
    assign OUT_DATE     = date_q;
    assign OUT_SEC_TICK = tick_q;
    assign OUT_SET_ERR  = err_q;

endmodule

// File: tb/tb_rtc_time_date_counter.sv
// Scoreboard bench for rtc_time_date_counter with CLK_HZ = 4.
// Expected tick/error events are queued by the driver, popped by a monitor.
module tb_rtc_time_date_counter;

    localparam int CLK_HZ = 4;
    localparam logic [1:0] K_TICK = 2'b10;
    localparam logic [1:0] K_ERR  = 2'b01;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        IN_RUN = 1'b1;
    logic        IN_SET_TIME = 1'b0;
    logic [16:0] IN_TIME_VAL = '0;
    logic        IN_SET_DATE = 1'b0;
    logic [15:0] IN_DATE_VAL = '0;
    logic [16:0] OUT_TIME;
    logic [15:0] OUT_DATE;
    logic        OUT_SEC_TICK;
    logic        OUT_SET_ERR;

    rtc_time_date_counter #(
        .CLK_HZ   (CLK_HZ),
        .RST_YEAR (16)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .IN_RUN       (IN_RUN),
        .IN_SET_TIME  (IN_SET_TIME),
        .IN_TIME_VAL  (IN_TIME_VAL),
        .IN_SET_DATE  (IN_SET_DATE),
        .IN_DATE_VAL  (IN_DATE_VAL),
        .OUT_TIME     (OUT_TIME),
        .OUT_DATE     (OUT_DATE),
        .OUT_SEC_TICK (OUT_SEC_TICK),
        .OUT_SET_ERR  (OUT_SET_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  kind;
        logic [16:0] t;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    function automatic logic [16:0] mk_t(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] mk_d(input int y, input int mo, input int d);
        return {7'(y), 4'(mo), 5'(d)};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESETN && (OUT_SEC_TICK || OUT_SET_ERR)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: tick=%0b err=%0b time=%h date=%h",
                         OUT_SEC_TICK, OUT_SET_ERR, OUT_TIME, OUT_DATE);
            end else begin
                mon_e = q.pop_front();
                check("event_kind", {30'd0, OUT_SEC_TICK, OUT_SET_ERR}, {30'd0, mon_e.kind});
                check("event_time", OUT_TIME, mon_e.t);
                check("event_date", OUT_DATE, mon_e.d);
            end
        end
    end

    task automatic wait_drain(input string name, output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d events outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic set_both(input logic [16:0] t, input logic [15:0] d);
        @(negedge CLK);
        IN_SET_TIME = 1'b1;
        IN_SET_DATE = 1'b1;
        IN_TIME_VAL = t;
        IN_DATE_VAL = d;
        @(negedge CLK);
        IN_SET_TIME = 1'b0;
        IN_SET_DATE = 1'b0;
        check("set_time_load", OUT_TIME, t);
        check("set_date_load", OUT_DATE, d);
    endtask

    task automatic bad_set(input string name, input logic st, input logic sd,
                           input logic [16:0] t, input logic [15:0] d,
                           input logic [16:0] et, input logic [15:0] ed);
        int c;
        q.push_back('{K_ERR, et, ed});
        @(negedge CLK);
        IN_SET_TIME = st;
        IN_SET_DATE = sd;
        IN_TIME_VAL = t;
        IN_DATE_VAL = d;
        @(negedge CLK);
        IN_SET_TIME = 1'b0;
        IN_SET_DATE = 1'b0;
        wait_drain(name, c);
        @(negedge CLK);
        check({name, "_time_hold"}, OUT_TIME, et);
        check({name, "_date_hold"}, OUT_DATE, ed);
    endtask

    initial begin
        #12;
        check("reset_time", OUT_TIME, mk_t(0, 0, 0));
        check("reset_date", OUT_DATE, mk_d(16, 1, 1));
        check("reset_tick", {31'd0, OUT_SEC_TICK}, 0);
        check("reset_err", {31'd0, OUT_SET_ERR}, 0);

        @(negedge CLK);
        RESETN = 1'b1;
        q.push_back('{K_TICK, mk_t(0, 0, 1), mk_d(16, 1, 1)});
        wait_drain("first_tick", n);
        check("first_tick_latency", n, CLK_HZ);

        set_both(mk_t(23, 59, 59), mk_d(16, 2, 28));
        q.push_back('{K_TICK, mk_t(0, 0, 0), mk_d(16, 2, 29)});
        wait_drain("leap_feb28", n);
        check("tick_after_set_latency", n, CLK_HZ);

        set_both(mk_t(23, 59, 59), mk_d(16, 2, 29));
        q.push_back('{K_TICK, mk_t(0, 0, 0), mk_d(16, 3, 1)});
        wait_drain("leap_feb29", n);

        set_both(mk_t(23, 59, 59), mk_d(17, 2, 28));
        q.push_back('{K_TICK, mk_t(0, 0, 0), mk_d(17, 3, 1)});
        wait_drain("nonleap_feb28", n);

        set_both(mk_t(23, 59, 59), mk_d(99, 12, 31));
        q.push_back('{K_TICK, mk_t(0, 0, 0), mk_d(0, 1, 1)});
        wait_drain("century_wrap", n);

        IN_RUN = 1'b0;
        set_both(mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_hour", 1'b1, 1'b0, mk_t(24, 0, 0), '0,
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_min", 1'b1, 1'b0, mk_t(10, 60, 0), '0,
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_sec", 1'b1, 1'b0, mk_t(10, 20, 60), '0,
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_feb29", 1'b0, 1'b1, '0, mk_d(17, 2, 29),
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_month", 1'b0, 1'b1, '0, mk_d(16, 13, 1),
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("bad_day0", 1'b0, 1'b1, '0, mk_d(16, 5, 0),
                mk_t(10, 20, 30), mk_d(16, 5, 15));
        bad_set("mixed_set", 1'b1, 1'b1, mk_t(1, 2, 3), mk_d(16, 2, 30),
                mk_t(1, 2, 3), mk_d(16, 5, 15));

        repeat (10 * CLK_HZ) @(negedge CLK);
        check("frozen_time", OUT_TIME, mk_t(1, 2, 3));
        check("frozen_date", OUT_DATE, mk_d(16, 5, 15));

        set_both(mk_t(1, 0, 0), mk_d(16, 5, 15));
        IN_RUN = 1'b1;
        q.push_back('{K_TICK, mk_t(1, 0, 1), mk_d(16, 5, 15)});
        wait_drain("run_resume", n);
        check("run_resume_latency", n, CLK_HZ);

        repeat (CLK_HZ - 1) @(negedge CLK);
        IN_SET_TIME = 1'b1;
        IN_TIME_VAL = mk_t(12, 34, 56);
        @(negedge CLK);
        IN_SET_TIME = 1'b0;
        check("set_on_tick_time", OUT_TIME, mk_t(12, 34, 56));
        check("set_on_tick_no_tick", {31'd0, OUT_SEC_TICK}, 0);
        q.push_back('{K_TICK, mk_t(12, 34, 57), mk_d(16, 5, 15)});
        wait_drain("after_set_on_tick", n);
        check("after_set_on_tick_latency", n, CLK_HZ);

        @(negedge CLK);
        IN_SET_TIME = 1'b1;
        IN_TIME_VAL = mk_t(23, 59, 59);
        @(negedge CLK);
        IN_SET_TIME = 1'b0;
        repeat (CLK_HZ - 1) @(negedge CLK);
        q.push_back('{K_TICK, mk_t(0, 0, 0), mk_d(20, 7, 4)});
        IN_SET_DATE = 1'b1;
        IN_DATE_VAL = mk_d(20, 7, 4);
        @(negedge CLK);
        IN_SET_DATE = 1'b0;
        wait_drain("midnight_date_set", n);
        check("midnight_set_time", OUT_TIME, mk_t(0, 0, 0));
        check("midnight_set_date", OUT_DATE, mk_d(20, 7, 4));

        @(negedge CLK);
        @(negedge CLK);
        #2;
        RESETN = 1'b0;
        #1;
        check("async_reset_time", OUT_TIME, mk_t(0, 0, 0));
        check("async_reset_date", OUT_DATE, mk_d(16, 1, 1));
        check("async_reset_tick", {31'd0, OUT_SEC_TICK}, 0);
        check("async_reset_err", {31'd0, OUT_SET_ERR}, 0);
        @(negedge CLK);
        RESETN = 1'b1;
        q.push_back('{K_TICK, mk_t(0, 0, 1), mk_d(16, 1, 1)});
        wait_drain("tick_after_rerelease", n);
        check("rerelease_latency", n, CLK_HZ);

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
